// File: rtl/three_bcd_down_counter.sv
// ---------------------------------------------------------------------------
// three_bcd_down_counter
//
// Registered 3-digit packed-BCD down-counter. It is the decrementing
// counterpart of the three-digit BCD incrementor, and its load port accepts
// that block's output format unchanged.
//
// Parameters
//   WRAP  1: decrementing 000 gives 999.  0: the count saturates at 000.
//
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   synchronous, active-high reset
//   load  in   1   parallel-load strobe (priority over en)
//   A     in  12   load value, packed BCD {hundreds, tens, units}
//   en    in   1   decrement enable
//   out   out 12   current count, packed BCD, same digit order as A
//   V     out  1   underflow pulse (borrow out of the hundreds digit)
//   zero  out  1   high while out == 000
//   err   out  1   pulse for a load rejected because A held a non-BCD nibble
//
// Per-cycle priority: rst > load > en > hold. Every output is registered.
// ---------------------------------------------------------------------------
module three_bcd_down_counter #(
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] A,
  input  logic        en,
  output logic [11:0] out,
  output logic        V,
  output logic        zero,
  output logic        err
);

  // A nibble is a legal BCD digit when it is 0..9.
  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // The whole packed word is legal only when all three digits are.
  function automatic logic bcd_ok(input logic [11:0] v);
    return digit_ok(v[11:8]) & digit_ok(v[7:4]) & digit_ok(v[3:0]);
  endfunction

  // One digit of the borrow chain: returns {borrow_out, new_digit}.
  // A digit only moves when the stage below it borrows.
  function automatic logic [4:0] digit_dec(input logic [3:0] d,
                                           input logic       borrow_in);
    logic [4:0] r;
    if (!borrow_in) begin
      r = {1'b0, d};
    end else if (d == 4'd0) begin
      r = {1'b1, 4'd9};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  // Full three-digit decrement: returns {borrow_out_of_hundreds, new_value}.
  function automatic logic [12:0] bcd_dec(input logic [11:0] v);
    logic [4:0] u;
    logic [4:0] t;
    logic [4:0] h;
    u = digit_dec(v[3:0],  1'b1);
    t = digit_dec(v[7:4],  u[4]);
    h = digit_dec(v[11:8], t[4]);
    return {h[4], h[3:0], t[3:0], u[3:0]};
  endfunction

  logic [11:0] count_r;
  logic        v_r;
  logic        zero_r;
  logic        err_r;

  logic [11:0] count_next_s;
  logic        v_next_s;
  logic        err_next_s;
  logic [12:0] dec_s;

  assign dec_s = bcd_dec(count_r);

  // Next-state selection: load beats en, en beats hold.
  always_comb begin
    count_next_s = count_r;
    v_next_s     = 1'b0;
    err_next_s   = 1'b0;
    if (load) begin
      // A rejected load leaves the count alone and also swallows en.
      if (bcd_ok(A)) begin
        count_next_s = A;
      end else begin
        err_next_s = 1'b1;
      end
    end else if (en) begin
      if (dec_s[12]) begin
        // Borrow out of hundreds only happens from 000.
        v_next_s = 1'b1;
        if (WRAP) begin
          count_next_s = 12'h999;
        end else begin
          count_next_s = 12'h000;
        end
      end else begin
        count_next_s = dec_s[11:0];
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // State and flag registers; zero is derived from the next count so it
  // always matches out in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 12'h000;
      v_r     <= 1'b0;
      zero_r  <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      v_r     <= v_next_s;
      zero_r  <= (count_next_s == 12'h000);
      err_r   <= err_next_s;
    end
  end

  assign out  = count_r;
  assign V    = v_r;
  assign zero = zero_r;
  assign err  = err_r;

endmodule

// File: tb/tb_three_bcd_down_counter.sv
// ---------------------------------------------------------------------------
// tb_three_bcd_down_counter
//
// Drives a wrapping (WRAP=1) and a saturating (WRAP=0) instance from the same
// inputs. A decimal-integer model of each counter is compared against both
// DUTs on every falling edge; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_three_bcd_down_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic [11:0] A = 12'h000;

  logic [11:0] out_w, out_s;
  logic        v_w, v_s, zero_w, zero_s, err_w, err_s;

  int tests = 0;
  int fails = 0;

  // Model state: index 0 = wrapping instance, index 1 = saturating instance.
  int m_cnt [2];
  bit m_v   [2];
  bit m_err [2];
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  three_bcd_down_counter #(.WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .load(load), .A(A), .en(en),
    .out(out_w), .V(v_w), .zero(zero_w), .err(err_w)
  );

  three_bcd_down_counter #(.WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .load(load), .A(A), .en(en),
    .out(out_s), .V(v_s), .zero(zero_s), .err(err_s)
  );

  function automatic bit is_bcd(input logic [11:0] x);
    return (x[11:8] <= 4'd9) && (x[7:4] <= 4'd9) && (x[3:0] <= 4'd9);
  endfunction

  function automatic int bcd_val(input logic [11:0] x);
    return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[11:8] = 4'(n / 100);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {11'b0, act}, {11'b0, exp});
  endtask

  // Reference model: plain decimal counting from the behavioural rules.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0;
        m_v[i]   = 1'b0;
        m_err[i] = 1'b0;
      end else if (load) begin
        m_v[i] = 1'b0;
        if (is_bcd(A)) begin
          m_cnt[i] = bcd_val(A);
          m_err[i] = 1'b0;
        end else begin
          m_err[i] = 1'b1;
        end
      end else if (en) begin
        m_err[i] = 1'b0;
        if (m_cnt[i] == 0) begin
          m_v[i]   = 1'b1;
          m_cnt[i] = (i == 0) ? 999 : 0;
        end else begin
          m_v[i]   = 1'b0;
          m_cnt[i] = m_cnt[i] - 1;
        end
      end else begin
        m_v[i]   = 1'b0;
        m_err[i] = 1'b0;
      end
    end
    if (rst) model_ok = 1'b1;
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check ("w.out",  out_w,  to_bcd(m_cnt[0]));
      check1("w.V",    v_w,    m_v[0]);
      check1("w.zero", zero_w, m_cnt[0] == 0);
      check1("w.err",  err_w,  m_err[0]);
      check ("s.out",  out_s,  to_bcd(m_cnt[1]));
      check1("s.V",    v_s,    m_v[1]);
      check1("s.zero", zero_s, m_cnt[1] == 0);
      check1("s.err",  err_s,  m_err[1]);
    end
  end

  // Apply inputs for one cycle; returns just after the capturing edge.
  task automatic cyc(input bit r, input bit l, input logic [11:0] a,
                     input bit e);
    rst  = r;
    load = l;
    A    = a;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcnt;
    int vat;
    logic [11:0] ra;

    // Reset then hold.
    cyc(1'b1, 1'b0, 12'h000, 1'b0);
    check ("lit.rst.out",  out_w, 12'h000);
    check1("lit.rst.zero", zero_w, 1'b1);
    check1("lit.rst.V",    v_w, 1'b0);
    check1("lit.rst.err",  err_w, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0);
    check ("lit.hold.out", out_w, 12'h000);
    check1("lit.hold.zero", zero_w, 1'b1);

    // Borrow chain.
    cyc(1'b0, 1'b1, 12'h100, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("lit.100-1", out_w, 12'h099);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("lit.099-1", out_w, 12'h098);
    cyc(1'b0, 1'b1, 12'h010, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("lit.010-1", out_w, 12'h009);

    // Wrap on the WRAP=1 instance.
    cyc(1'b0, 1'b1, 12'h001, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check ("lit.wrap.000", out_w, 12'h000);
    check1("lit.wrap.zero", zero_w, 1'b1);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check ("lit.wrap.999", out_w, 12'h999);
    check1("lit.wrap.V", v_w, 1'b1);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check ("lit.wrap.998", out_w, 12'h998);
    check1("lit.wrap.V0", v_w, 1'b0);

    // Saturation on the WRAP=0 instance.
    cyc(1'b0, 1'b1, 12'h000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 12'h000, 1'b1);
      check ("lit.sat.out", out_s, 12'h000);
      check1("lit.sat.V",   v_s, 1'b1);
    end
    // Load at 000 with en: load wins, no underflow.
    cyc(1'b0, 1'b1, 12'h000, 1'b1);
    check1("lit.ldund.V", v_s, 1'b0);

    // Invalid load, then load with en.
    cyc(1'b0, 1'b1, 12'h045, 1'b0);
    cyc(1'b0, 1'b1, 12'h0A3, 1'b1);
    check ("lit.bad.out", out_w, 12'h045);
    check1("lit.bad.err", err_w, 1'b1);
    cyc(1'b0, 1'b1, 12'h999, 1'b1);
    check ("lit.ld_en.out", out_w, 12'h999);
    check1("lit.ld_en.err", err_w, 1'b0);

    // Mid-count reset overrides load and en.
    cyc(1'b0, 1'b1, 12'h500, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 12'h000, 1'b1);
    cyc(1'b1, 1'b1, 12'h321, 1'b1);
    check ("lit.midrst.out", out_w, 12'h000);
    check1("lit.midrst.zero", zero_w, 1'b1);
    check1("lit.midrst.V", v_w, 1'b0);

    // Full countdown: V fires exactly once, on the 1000th enabled cycle.
    cyc(1'b0, 1'b1, 12'h999, 1'b0);
    vcnt = 0;
    vat  = 0;
    for (int k = 1; k <= 1000; k++) begin
      cyc(1'b0, 1'b0, 12'h000, 1'b1);
      if (v_w) begin
        vcnt++;
        vat = k;
      end
      if (k == 999) check("lit.full.000", out_w, 12'h000);
      if (k == 1000) check("lit.full.999", out_w, 12'h999);
    end
    check("lit.full.vcount", 12'(vcnt), 12'd1);
    check("lit.full.vat", 12'(vat), 12'd1000);

    // Randomized traffic, biased towards small counts to hit underflow.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 12'($urandom_range(0, 4095));
        1:       ra = to_bcd($urandom_range(0, 3));
        default: ra = to_bcd($urandom_range(0, 999));
      endcase
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 7) == 0,
          ra,
          $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
